pedestrian_request_ctrl: RTL

PEDESTRIAN_REQUEST_CTRL -- requirements
Module: pedestrian_request_ctrl

---
 rtl/pedestrian_request_ctrl_if.sv | 20 ++
 rtl/pedestrian_request_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pedestrian_request_ctrl_if.sv
// Board-side signals of the pedestrian crossing controller: push-button in, lamps out.
interface pedestrian_request_ctrl_if;
    logic pin10_button;
    logic pin4_green;
    logic pin5_yellow;
    logic pin6_red;
    logic pin7_ped_green;
    logic pin8_ped_red;
    logic pin11_wait;

    modport master (
        output pin10_button,
        input  pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, pin11_wait
    );

    modport slave (
        input  pin10_button,
        output pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, pin11_wait
    );
endinterface

// File: rtl/pedestrian_request_ctrl.sv
// Pedestrian crossing controller: button request latch, timed phase FSM and lamp decode.
// Lamps are decoded from registered state only, so they follow reset without a clock.
module pedestrian_request_ctrl #(
    parameter int unsigned TIMER_SCALE = 16000000,
    parameter int unsigned GREEN_MIN   = 10,
    parameter int unsigned YELLOW_T    = 3,
    parameter int unsigned ALLRED_T    = 2,
    parameter int unsigned WALK_T      = 8,
    parameter int unsigned FLASH_T     = 4
) (
    input  logic                      pin3_clk_16mhz,
    input  logic                      pin9_rst_n,
    pedestrian_request_ctrl_if.slave  lamp_if
);

    localparam int unsigned MAX_A = (GREEN_MIN > YELLOW_T) ? GREEN_MIN : YELLOW_T;
    localparam int unsigned MAX_B = (MAX_A > ALLRED_T) ? MAX_A : ALLRED_T;
    localparam int unsigned MAX_C = (MAX_B > WALK_T) ? MAX_B : WALK_T;
    localparam int unsigned MAX_D = (MAX_C > FLASH_T) ? MAX_C : FLASH_T;
    localparam int unsigned PW    = $clog2(TIMER_SCALE + 1);
    localparam int unsigned UW    = $clog2(MAX_D + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_SCALE - 1);

    typedef enum logic [2:0] {
        CAR_GREEN,
        CAR_YELLOW,
        ALL_RED1,
        PED_WALK,
        PED_FLASH,
        ALL_RED2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [2:0]    sync_q, sync_d;
    logic          req_q, req_d;
    logic          wrap;
    logic          rise;

    always_ff @(posedge pin3_clk_16mhz or negedge pin9_rst_n) begin
        if (!pin9_rst_n) begin
            state_q <= CAR_GREEN;
            presc_q <= '0;
            unit_q  <= '0;
            sync_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            unit_q  <= unit_d;
            sync_q  <= sync_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q + PW'(1);
        unit_d  = unit_q;
        sync_d  = {sync_q[1:0], lamp_if.pin10_button};
        req_d   = req_q;
        wrap    = (presc_q == PRESC_LAST);
        rise    = sync_q[1] & ~sync_q[2];

        if (wrap) begin
            presc_d = '0;
            unit_d  = unit_q + UW'(1);
        end

        // Timed phases leave on the wrap that would complete their last unit.
        case (state_q)
            CAR_GREEN: begin
                if (wrap && (unit_q == UW'(GREEN_MIN))) unit_d = unit_q;
                if (req_q && ((unit_q == UW'(GREEN_MIN)) ||
                              (wrap && (unit_q == UW'(GREEN_MIN - 1)))))
                    state_d = CAR_YELLOW;
            end
            CAR_YELLOW: if (wrap && (unit_q == UW'(YELLOW_T - 1))) state_d = ALL_RED1;
            ALL_RED1:   if (wrap && (unit_q == UW'(ALLRED_T - 1))) state_d = PED_WALK;
            PED_WALK:   if (wrap && (unit_q == UW'(WALK_T - 1)))   state_d = PED_FLASH;
            PED_FLASH:  if (wrap && (unit_q == UW'(FLASH_T - 1)))  state_d = ALL_RED2;
            ALL_RED2:   if (wrap && (unit_q == UW'(ALLRED_T - 1))) state_d = CAR_GREEN;
            default:    state_d = CAR_GREEN;
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            unit_d  = '0;
        end

        // Clear on walk entry is applied last so it beats a same-cycle press.
        if (rise && (state_q != PED_WALK)) req_d = 1'b1;
        if ((state_d == PED_WALK) && (state_q != PED_WALK)) req_d = 1'b0;
    end

    always_comb begin
        lamp_if.pin4_green     = 1'b0;
        lamp_if.pin5_yellow    = 1'b0;
        lamp_if.pin6_red       = 1'b0;
        lamp_if.pin7_ped_green = 1'b0;
        lamp_if.pin8_ped_red   = 1'b0;
        lamp_if.pin11_wait     = req_q;
        case (state_q)
            CAR_GREEN: begin
                lamp_if.pin4_green   = 1'b1;
                lamp_if.pin8_ped_red = 1'b1;
            end
            CAR_YELLOW: begin
                lamp_if.pin5_yellow  = 1'b1;
                lamp_if.pin8_ped_red = 1'b1;
            end
            PED_WALK: begin
                lamp_if.pin6_red       = 1'b1;
                lamp_if.pin7_ped_green = 1'b1;
            end
            PED_FLASH: begin
                lamp_if.pin6_red       = 1'b1;
                lamp_if.pin7_ped_green = ~unit_q[0];
            end
            default: begin
                lamp_if.pin6_red     = 1'b1;
                lamp_if.pin8_ped_red = 1'b1;
            end
        endcase
    end

endmodule
